// File: rtl/rr_blocking_accumulator_if.sv
// Blocking handshake bundle for rr_blocking_accumulator: NUM_CH sync/notify input
// ports and one sync/notify output port.
interface rr_blocking_accumulator_if #(
  parameter int NUM_CH = 4,
  parameter int WIDTH  = 32
);
  logic [NUM_CH*WIDTH-1:0] in_data;
  logic [NUM_CH-1:0]       in_sync;
  logic [NUM_CH-1:0]       in_notify;
  logic [NUM_CH-1:0]       ch_enable;
  logic signed [WIDTH-1:0] out_data;
  logic                    out_sync;
  logic                    out_notify;

  modport master (
    output in_data, in_sync, ch_enable, out_sync,
    input  in_notify, out_data, out_notify
  );

  modport slave (
    input  in_data, in_sync, ch_enable, out_sync,
    output in_notify, out_data, out_notify
  );
endinterface

// File: rtl/rr_blocking_accumulator.sv
// Round-robin blocking reader: sums BATCH signed words taken from the enabled
// channels in wrap order, then offers the sum on a blocking output port.
module rr_blocking_accumulator #(
  parameter int NUM_CH = 4,
  parameter int WIDTH  = 32,
  parameter int BATCH  = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  rr_blocking_accumulator_if.slave     bus,
  output logic                         section_o,
  output logic [$clog2(BATCH+1)-1:0]   count_o
);

  localparam int IDX_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int CNT_W = $clog2(BATCH + 1);

  typedef enum logic {SEC_READ = 1'b0, SEC_WRITE = 1'b1} section_t;

  section_t                section_q;
  logic [IDX_W-1:0]        ch_idx_q;
  logic [NUM_CH-1:0]       notify_q;
  logic                    out_notify_q;
  logic [CNT_W-1:0]        count_q;
  logic signed [WIDTH-1:0] acc_q;
  logic signed [WIDTH-1:0] out_q;

  logic                    rd_fire;
  logic signed [WIDTH-1:0] rd_word;
  logic signed [WIDTH-1:0] acc_sum;
  logic                    nxt_found;
  logic [IDX_W-1:0]        nxt_idx;
  logic                    here_found;
  logic [IDX_W-1:0]        here_idx;

  // Two's complement sum; overflow wraps, never saturates.
  function automatic logic signed [WIDTH-1:0] wrap_add(
    input logic signed [WIDTH-1:0] a,
    input logic signed [WIDTH-1:0] b
  );
    return a + b;
  endfunction

  // First enabled channel scanning start, start+1, ... modulo NUM_CH; MSB = found.
  function automatic logic [IDX_W:0] find_enabled(
    input logic [NUM_CH-1:0] mask,
    input int                start
  );
    logic             found;
    logic [IDX_W-1:0] idx;
    logic [IDX_W-1:0] pos;
    found = 1'b0;
    idx   = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      pos = IDX_W'((start + k) % NUM_CH);
      if (!found && mask[pos]) begin
        found = 1'b1;
        idx   = pos;
      end
    end
    return {found, idx};
  endfunction

  function automatic logic [NUM_CH-1:0] onehot(input logic [IDX_W-1:0] idx);
    return NUM_CH'(1) << idx;
  endfunction

  always_comb begin
    rd_fire = |(notify_q & bus.in_sync);
    rd_word = $signed(WIDTH'(bus.in_data >> (int'(ch_idx_q) * WIDTH)));
    acc_sum = wrap_add(acc_q, rd_word);
    {nxt_found, nxt_idx}   = find_enabled(bus.ch_enable, int'(ch_idx_q) + 1);
    {here_found, here_idx} = find_enabled(bus.ch_enable, int'(ch_idx_q));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      section_q    <= SEC_READ;
      ch_idx_q     <= '0;
      notify_q     <= NUM_CH'(bus.ch_enable[0]);
      out_notify_q <= 1'b0;
      count_q      <= '0;
      acc_q        <= '0;
      out_q        <= '0;
    end else begin
      case (section_q)
        SEC_READ: begin
          if (notify_q != '0) begin
            if (rd_fire) begin
              acc_q   <= acc_sum;
              count_q <= count_q + CNT_W'(1);
              if (nxt_found) ch_idx_q <= nxt_idx;
              if (count_q == CNT_W'(BATCH - 1)) begin
                section_q    <= SEC_WRITE;
                out_q        <= acc_sum;
                out_notify_q <= 1'b1;
                notify_q     <= '0;
              end else begin
                notify_q <= nxt_found ? onehot(nxt_idx) : '0;
              end
            end
          end else if (here_found) begin
            // Idle: re-arm on the first enabled channel, current one included.
            ch_idx_q <= here_idx;
            notify_q <= onehot(here_idx);
          end
        end
        SEC_WRITE: begin
          if (bus.out_sync) begin
            section_q    <= SEC_READ;
            out_notify_q <= 1'b0;
            acc_q        <= '0;
            count_q      <= '0;
            if (here_found) begin
              ch_idx_q <= here_idx;
              notify_q <= onehot(here_idx);
            end
          end
        end
        default: section_q <= SEC_READ;
      endcase
    end
  end

  assign bus.in_notify  = notify_q;
  assign bus.out_notify = out_notify_q;
  assign bus.out_data   = out_q;
  assign section_o      = (section_q == SEC_WRITE);
  assign count_o        = count_q;

endmodule

// File: tb/tb_rr_blocking_accumulator.sv
// Bench for rr_blocking_accumulator (4 channels, 8-bit words, batch of 4):
// directed scenarios with literal expectations plus a randomized run against a model.
module tb_rr_blocking_accumulator;
  localparam int NCH = 4;
  localparam int W   = 8;
  localparam int B   = 4;

  logic clk;
  logic rst;
  logic section_o;
  logic [$clog2(B+1)-1:0] count_o;

  rr_blocking_accumulator_if #(.NUM_CH(NCH), .WIDTH(W)) bus ();

  rr_blocking_accumulator #(.NUM_CH(NCH), .WIDTH(W), .BATCH(B)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .section_o (section_o),
    .count_o   (count_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // Reference model: which channel is offered (-1 = none), the rotation pointer,
  // running sum, words taken, whether the sum is on offer, and the offered sum.
  int                m_sel;
  int                m_ch;
  int                m_cnt;
  bit                m_write;
  logic signed [W-1:0] m_acc;
  logic signed [W-1:0] m_out;

  function automatic int first_enabled(input logic [NCH-1:0] mask, input int start);
    logic [1:0] idx;
    for (int k = 0; k < NCH; k++) begin
      idx = 2'((start + k) % NCH);
      if (mask[idx]) return int'(idx);
    end
    return -1;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_sel = bus.ch_enable[0] ? 0 : -1;
      m_ch = 0; m_cnt = 0; m_write = 0; m_acc = '0; m_out = '0;
    end else if (m_write) begin
      if (bus.out_sync) begin
        m_write = 0; m_acc = '0; m_cnt = 0;
        m_sel = first_enabled(bus.ch_enable, m_ch);
        if (m_sel >= 0) m_ch = m_sel;
      end
    end else if (m_sel < 0) begin
      m_sel = first_enabled(bus.ch_enable, m_ch);
      if (m_sel >= 0) m_ch = m_sel;
    end else if (bus.in_sync[m_sel[1:0]]) begin
      int nxt;
      m_acc = m_acc + $signed(W'(bus.in_data >> (W * m_sel)));
      m_cnt++;
      nxt = first_enabled(bus.ch_enable, m_ch + 1);
      if (nxt >= 0) m_ch = nxt;
      if (m_cnt == B) begin
        m_write = 1; m_out = m_acc; m_sel = -1;
      end else begin
        m_sel = nxt;
      end
    end
  end

  // Cycle-by-cycle comparison of every output against the model.
  always @(negedge clk) begin
    check("in_notify", {28'b0, bus.in_notify}, (m_sel >= 0) ? (32'd1 << m_sel) : 32'd0);
    check("out_notify", {31'b0, bus.out_notify}, {31'b0, m_write});
    check("out_data", {24'b0, bus.out_data}, {24'b0, m_out});
    check("section", {31'b0, section_o}, {31'b0, m_write});
    check("count", {29'b0, count_o}, 32'(m_cnt));
    check("notify_onehot", {31'b0, $onehot0(bus.in_notify)}, 32'd1);
    check("notify_exclusive", {31'b0, (|bus.in_notify) & bus.out_notify}, 32'd0);
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset(input logic [NCH-1:0] en);
    #2;
    bus.ch_enable = en;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  logic [3:0] seq_all [4] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};
  logic [3:0] seq_odd [4] = '{4'b0001, 4'b0100, 4'b0001, 4'b0100};

  initial begin
    rst = 1'b1;
    bus.ch_enable = 4'hF;
    bus.in_sync = '0;
    bus.out_sync = 1'b0;
    bus.in_data = '0;

    @(negedge clk);
    check("rst_in_notify", {28'b0, bus.in_notify}, 32'h1);
    check("rst_out_notify", {31'b0, bus.out_notify}, 32'h0);
    check("rst_out_data", {24'b0, bus.out_data}, 32'h0);
    check("rst_section", {31'b0, section_o}, 32'h0);
    check("rst_count", {29'b0, count_o}, 32'h0);
    rst = 1'b0;

    // Full-rate walk over all channels, then a stalled output port.
    bus.in_data = {8'd4, 8'd3, 8'd2, 8'd1};
    bus.in_sync = 4'hF;
    for (int i = 0; i < 4; i++) begin
      check("walk_notify", {28'b0, bus.in_notify}, {28'b0, seq_all[i]});
      @(negedge clk);
    end
    check("sum10_notify", {31'b0, bus.out_notify}, 32'h1);
    check("sum10_data", {24'b0, bus.out_data}, 32'd10);
    check("sum10_section", {31'b0, section_o}, 32'h1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("hold_data", {24'b0, bus.out_data}, 32'd10);
      check("hold_in_notify", {28'b0, bus.in_notify}, 32'h0);
    end
    bus.out_sync = 1'b1;
    @(negedge clk);
    bus.out_sync = 1'b0;
    bus.in_sync = '0;
    check("release_notify", {28'b0, bus.in_notify}, 32'h1);
    check("release_count", {29'b0, count_o}, 32'h0);
    check("release_keep_data", {24'b0, bus.out_data}, 32'd10);

    // Masked rotation over channels 0 and 2.
    do_reset(4'b0101);
    bus.in_data = {4{8'd7}};
    bus.in_sync = 4'hF;
    for (int i = 0; i < 4; i++) begin
      check("mask_notify", {28'b0, bus.in_notify}, {28'b0, seq_odd[i]});
      @(negedge clk);
    end
    check("mask_sum", {24'b0, bus.out_data}, 32'd28);
    bus.out_sync = 1'b1;
    cyc(1);
    bus.out_sync = 1'b0;
    bus.in_sync = '0;

    // Nothing enabled: stay idle until a channel appears.
    do_reset(4'b0000);
    for (int i = 0; i < 5; i++) begin
      check("idle_notify", {28'b0, bus.in_notify}, 32'h0);
      @(negedge clk);
    end
    bus.ch_enable = 4'b1000;
    @(negedge clk);
    check("wake_notify", {28'b0, bus.in_notify}, 32'h8);

    // Wrap-around arithmetic.
    do_reset(4'hF);
    bus.in_data = {4{8'd100}};
    bus.in_sync = 4'hF;
    cyc(4);
    check("wrap_pos", {24'b0, bus.out_data}, 32'h90);
    bus.in_data = {4{8'hFD}};
    bus.out_sync = 1'b1;
    cyc(1);
    bus.out_sync = 1'b0;
    cyc(4);
    check("wrap_neg", {24'b0, bus.out_data}, 32'hF4);
    bus.out_sync = 1'b1;
    cyc(1);
    bus.out_sync = 1'b0;
    bus.in_sync = '0;

    // Reset in the middle of a batch discards it.
    do_reset(4'hF);
    bus.in_data = {4{8'd9}};
    bus.in_sync = 4'hF;
    cyc(2);
    bus.in_sync = '0;
    check("mid_count", {29'b0, count_o}, 32'd2);
    #2 rst = 1'b1;
    #1;
    check("async_count", {29'b0, count_o}, 32'd0);
    check("async_section", {31'b0, section_o}, 32'd0);
    check("async_notify", {28'b0, bus.in_notify}, 32'h1);
    @(negedge clk);
    rst = 1'b0;
    bus.in_data = {4{8'd1}};
    bus.in_sync = 4'hF;
    cyc(4);
    check("after_rst_sum", {24'b0, bus.out_data}, 32'd4);
    bus.out_sync = 1'b1;
    cyc(1);
    bus.out_sync = 1'b0;

    // Randomized traffic with occasional mask changes and resets.
    do_reset(4'hF);
    for (int i = 0; i < 3000; i++) begin
      bus.in_data = $urandom;
      bus.in_sync = 4'($urandom);
      bus.out_sync = ($urandom_range(2) != 0);
      if ($urandom_range(7) == 0) bus.ch_enable = 4'($urandom);
      if ($urandom_range(399) == 0) begin
        do_reset(4'($urandom));
      end else begin
        @(negedge clk);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
